// File: rtl/ctrl_unit.sv
// RV32I main decoder: turns opcode/func3/func7 into datapath selects and enables.
// The only state is the LOAD phase bit, which splits LOAD into address and write-back cycles.
module ctrl_unit (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] opcode,
    input  logic [2:0] func3,
    input  logic [6:0] func7,
    input  logic       b,
    output logic [2:0] imm_type,
    output logic       alu1_sel,
    output logic       alu2_sel,
    output logic [3:0] alu_op,
    output logic [1:0] rd_sel,
    output logic       reg_wr,
    output logic [1:0] pc_sel,
    output logic [1:0] mem_sel,
    output logic       mem_wr,
    output logic [2:0] cmp_op,
    output logic [2:0] sel_type
);

    localparam logic [4:0] OPC_OP     = 5'b01100;
    localparam logic [4:0] OPC_OP_IMM = 5'b00100;
    localparam logic [4:0] OPC_LOAD   = 5'b00000;
    localparam logic [4:0] OPC_STORE  = 5'b01000;
    localparam logic [4:0] OPC_BRANCH = 5'b11000;
    localparam logic [4:0] OPC_JAL    = 5'b11011;
    localparam logic [4:0] OPC_JALR   = 5'b11001;
    localparam logic [4:0] OPC_LUI    = 5'b01101;
    localparam logic [4:0] OPC_AUIPC  = 5'b00101;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_SLL  = 4'b0010;
    localparam logic [3:0] ALU_SLT  = 4'b0011;
    localparam logic [3:0] ALU_SLTU = 4'b0100;
    localparam logic [3:0] ALU_XOR  = 4'b0101;
    localparam logic [3:0] ALU_SRL  = 4'b0110;
    localparam logic [3:0] ALU_SRA  = 4'b0111;
    localparam logic [3:0] ALU_OR   = 4'b1000;
    localparam logic [3:0] ALU_AND  = 4'b1001;

    typedef enum logic {
        PH_ADDR = 1'b0,
        PH_WB   = 1'b1
    } phase_e;

    phase_e load_phase_q;
    phase_e load_phase_d;
    logic   alt_q_bit;
    logic   unused_func7;

    // Only func7[5] distinguishes SUB/SRA; the remaining bits are don't-care.
    assign alt_q_bit    = func7[5];
    assign unused_func7 = ^{func7[6], func7[4:0]};

    always_ff @(posedge clk) begin
        if (!rst) begin
            load_phase_q <= PH_ADDR;
        end else begin
            load_phase_q <= load_phase_d;
        end
    end

    always_comb begin
        load_phase_d = PH_ADDR;
        if (opcode == OPC_LOAD && load_phase_q == PH_ADDR) begin
            load_phase_d = PH_WB;
        end
    end

    function automatic logic [3:0] arith_op(input logic [2:0] f3, input logic alt,
                                            input logic allow_sub);
        logic [3:0] op;
        op = ALU_ADD;
        unique case (f3)
            3'b000:  op = (allow_sub && alt) ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    always_comb begin
        imm_type = 3'b000;
        alu1_sel = 1'b0;
        alu2_sel = 1'b1;
        alu_op   = ALU_ADD;
        rd_sel   = 2'b10;
        reg_wr   = 1'b0;
        pc_sel   = 2'b01;
        mem_sel  = 2'b00;
        mem_wr   = 1'b0;
        case (opcode)
            OPC_OP: begin
                alu2_sel = 1'b0;
                alu_op   = arith_op(func3, alt_q_bit, 1'b1);
                reg_wr   = 1'b1;
            end
            OPC_OP_IMM: begin
                imm_type = 3'b100;
                alu_op   = arith_op(func3, alt_q_bit, 1'b0);
                reg_wr   = 1'b1;
            end
            OPC_LOAD: begin
                imm_type = 3'b100;
                rd_sel   = 2'b11;
                // Address phase stalls the PC and points memory at the ALU result.
                if (load_phase_q == PH_ADDR) begin
                    pc_sel  = 2'b10;
                    mem_sel = 2'b01;
                end else begin
                    reg_wr  = 1'b1;
                end
            end
            OPC_STORE: begin
                imm_type = 3'b011;
                mem_sel  = 2'b01;
                mem_wr   = 1'b1;
            end
            OPC_BRANCH: begin
                imm_type = 3'b101;
                alu1_sel = 1'b1;
                pc_sel   = b ? 2'b00 : 2'b01;
            end
            OPC_JAL: begin
                imm_type = 3'b010;
                alu1_sel = 1'b1;
                rd_sel   = 2'b01;
                reg_wr   = 1'b1;
                pc_sel   = 2'b00;
            end
            OPC_JALR: begin
                imm_type = 3'b100;
                rd_sel   = 2'b01;
                reg_wr   = 1'b1;
                pc_sel   = 2'b00;
            end
            OPC_LUI: begin
                imm_type = 3'b001;
                rd_sel   = 2'b00;
                reg_wr   = 1'b1;
            end
            OPC_AUIPC: begin
                imm_type = 3'b001;
                alu1_sel = 1'b1;
                reg_wr   = 1'b1;
            end
            default: begin
            end
        endcase
    end

    always_comb begin
        cmp_op = 3'b000;
        case (func3)
            3'b001:  cmp_op = 3'b001;
            3'b100:  cmp_op = 3'b010;
            3'b101:  cmp_op = 3'b011;
            3'b110:  cmp_op = 3'b100;
            3'b111:  cmp_op = 3'b101;
            default: cmp_op = 3'b000;
        endcase
    end

    always_comb begin
        sel_type = 3'b010;
        case (func3)
            3'b000:  sel_type = 3'b000;
            3'b001:  sel_type = 3'b001;
            3'b100:  sel_type = 3'b011;
            3'b101:  sel_type = 3'b100;
            default: sel_type = 3'b010;
        endcase
    end

endmodule

// File: tb/tb_ctrl_unit.sv
// Bench for ctrl_unit: expected field values are queued per transaction and
// popped once the decode has settled.
module tb_ctrl_unit;

    localparam logic [4:0] OPC_OP     = 5'b01100;
    localparam logic [4:0] OPC_OP_IMM = 5'b00100;
    localparam logic [4:0] OPC_LOAD   = 5'b00000;
    localparam logic [4:0] OPC_STORE  = 5'b01000;
    localparam logic [4:0] OPC_BRANCH = 5'b11000;
    localparam logic [4:0] OPC_JAL    = 5'b11011;
    localparam logic [4:0] OPC_JALR   = 5'b11001;
    localparam logic [4:0] OPC_LUI    = 5'b01101;
    localparam logic [4:0] OPC_AUIPC  = 5'b00101;

    localparam int F_IMM = 0, F_ALU1 = 1, F_ALU2 = 2, F_ALUOP = 3, F_RD = 4, F_REGWR = 5;
    localparam int F_PC = 6, F_MEMSEL = 7, F_MEMWR = 8, F_CMP = 9, F_SEL = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [4:0] opcode = OPC_LOAD;
    logic [2:0] func3 = 3'b000;
    logic [6:0] func7 = 7'b0;
    logic       b = 1'b0;
    logic [2:0] imm_type;
    logic       alu1_sel;
    logic       alu2_sel;
    logic [3:0] alu_op;
    logic [1:0] rd_sel;
    logic       reg_wr;
    logic [1:0] pc_sel;
    logic [1:0] mem_sel;
    logic       mem_wr;
    logic [2:0] cmp_op;
    logic [2:0] sel_type;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        string      tag;
        int         id;
        logic [3:0] val;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    ctrl_unit dut (
        .clk(clk), .rst(rst), .opcode(opcode), .func3(func3), .func7(func7), .b(b),
        .imm_type(imm_type), .alu1_sel(alu1_sel), .alu2_sel(alu2_sel), .alu_op(alu_op),
        .rd_sel(rd_sel), .reg_wr(reg_wr), .pc_sel(pc_sel), .mem_sel(mem_sel),
        .mem_wr(mem_wr), .cmp_op(cmp_op), .sel_type(sel_type)
    );

    task automatic check_eq(input string tag, input logic [3:0] got, input logic [3:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] observed(input int id);
        case (id)
            F_IMM:    return {1'b0, imm_type};
            F_ALU1:   return {3'b0, alu1_sel};
            F_ALU2:   return {3'b0, alu2_sel};
            F_ALUOP:  return alu_op;
            F_RD:     return {2'b0, rd_sel};
            F_REGWR:  return {3'b0, reg_wr};
            F_PC:     return {2'b0, pc_sel};
            F_MEMSEL: return {2'b0, mem_sel};
            F_MEMWR:  return {3'b0, mem_wr};
            F_CMP:    return {1'b0, cmp_op};
            default:  return {1'b0, sel_type};
        endcase
    endfunction

    task automatic drive(input logic [4:0] op, input logic [2:0] f3,
                         input logic [6:0] f7, input logic bb);
        opcode = op;
        func3  = f3;
        func7  = f7;
        b      = bb;
    endtask

    task automatic expect_f(input string tag, input int id, input logic [3:0] v);
        exp_t e;
        e.tag = tag;
        e.id  = id;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic settle_check(input string txn);
        int n;
        exp_t e;
        #1;
        n = sb.size();
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check_eq(e.tag, observed(e.id), e.val);
        end
        $display("txn %-14s op=%b f3=%b f7=%b b=%b checks=%0d", txn, opcode, func3, func7, b, n);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_load_addr(input string p);
        expect_f({p, "_pc"},  F_PC,     4'b0010);
        expect_f({p, "_mem"}, F_MEMSEL, 4'b0001);
        expect_f({p, "_wr"},  F_REGWR,  4'b0000);
        expect_f({p, "_rd"},  F_RD,     4'b0011);
    endtask

    task automatic expect_load_wb(input string p);
        expect_f({p, "_pc"},  F_PC,     4'b0001);
        expect_f({p, "_mem"}, F_MEMSEL, 4'b0000);
        expect_f({p, "_wr"},  F_REGWR,  4'b0001);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset held across two LOAD edges must keep the address phase.
        step();
        drive(OPC_LOAD, 3'b000, 7'b0, 1'b0);
        expect_load_addr("rst1");
        settle_check("reset1");
        step();
        expect_load_addr("rst2");
        settle_check("reset2");
        rst = 1'b1;

        drive(OPC_LUI, 3'b000, 7'b0, 1'b0);
        expect_f("lui_imm", F_IMM, 4'b0001);
        expect_f("lui_rd", F_RD, 4'b0000);
        expect_f("lui_wr", F_REGWR, 4'b0001);
        settle_check("lui");
        step();
        drive(OPC_OP_IMM, 3'b000, 7'b0, 1'b0);
        expect_f("opi_imm", F_IMM, 4'b0100);
        settle_check("op_imm");
        drive(OPC_STORE, 3'b010, 7'b0, 1'b0);
        expect_f("st_imm", F_IMM, 4'b0011);
        expect_f("st_mem", F_MEMSEL, 4'b0001);
        expect_f("st_memwr", F_MEMWR, 4'b0001);
        expect_f("st_wr", F_REGWR, 4'b0000);
        settle_check("store");
        step();

        drive(OPC_OP, 3'b000, 7'b0100000, 1'b0);
        expect_f("op_alu2", F_ALU2, 4'b0000);
        expect_f("op_sub", F_ALUOP, 4'b0001);
        settle_check("op_sub");
        drive(5'b10101, 3'b000, 7'b0, 1'b0);
        expect_f("undef_alu2", F_ALU2, 4'b0001);
        expect_f("undef_imm", F_IMM, 4'b0000);
        expect_f("undef_wr", F_REGWR, 4'b0000);
        expect_f("undef_rd", F_RD, 4'b0010);
        settle_check("undefined");
        drive(OPC_OP_IMM, 3'b000, 7'b0100000, 1'b0);
        expect_f("opi_alu2", F_ALU2, 4'b0001);
        expect_f("opi_add", F_ALUOP, 4'b0000);
        settle_check("op_imm_f7");
        drive(OPC_OP, 3'b101, 7'b0100000, 1'b0);
        expect_f("op_sra", F_ALUOP, 4'b0111);
        settle_check("op_sra");
        drive(OPC_OP_IMM, 3'b101, 7'b0000000, 1'b0);
        expect_f("opi_srl", F_ALUOP, 4'b0110);
        settle_check("op_imm_srl");
        drive(OPC_OP, 3'b111, 7'b0000000, 1'b0);
        expect_f("op_and", F_ALUOP, 4'b1001);
        settle_check("op_and");
        step();

        drive(OPC_BRANCH, 3'b000, 7'b0, 1'b0);
        expect_f("br_nt_pc", F_PC, 4'b0001);
        expect_f("br_alu1", F_ALU1, 4'b0001);
        expect_f("br_imm", F_IMM, 4'b0101);
        settle_check("branch_nt");
        drive(OPC_BRANCH, 3'b000, 7'b0, 1'b1);
        expect_f("br_t_pc", F_PC, 4'b0000);
        settle_check("branch_t");
        drive(OPC_JALR, 3'b000, 7'b0, 1'b0);
        expect_f("jalr_pc", F_PC, 4'b0000);
        expect_f("jalr_rd", F_RD, 4'b0001);
        expect_f("jalr_wr", F_REGWR, 4'b0001);
        expect_f("jalr_alu1", F_ALU1, 4'b0000);
        settle_check("jalr");
        drive(OPC_AUIPC, 3'b000, 7'b0, 1'b0);
        expect_f("auipc_alu1", F_ALU1, 4'b0001);
        expect_f("auipc_imm", F_IMM, 4'b0001);
        settle_check("auipc");
        step();

        // Two-cycle LOAD, then wrap back to the address phase.
        drive(OPC_LOAD, 3'b010, 7'b0, 1'b0);
        expect_load_addr("ld1");
        expect_f("ld1_alu1", F_ALU1, 4'b0000);
        settle_check("load_c1");
        step();
        expect_load_wb("ld2");
        settle_check("load_c2");
        step();
        expect_load_addr("ld3");
        settle_check("load_c3");
        step();
        expect_load_wb("ld4");
        settle_check("load_c4");

        // Reset in the write-back phase restarts the LOAD.
        rst = 1'b0;
        step();
        rst = 1'b1;
        expect_load_addr("ldrst");
        settle_check("load_reset");
        step();
        expect_load_wb("ldrst2");
        settle_check("load_reset_wb");

        // A non-LOAD opcode at an edge clears the phase.
        drive(OPC_OP, 3'b000, 7'b0, 1'b0);
        step();
        drive(OPC_LOAD, 3'b000, 7'b0, 1'b0);
        expect_load_addr("ldclr");
        settle_check("load_cleared");
        step();

        drive(OPC_STORE, 3'b000, 7'b0, 1'b0);
        step();
        drive(OPC_JAL, 3'b000, 7'b0, 1'b0);
        expect_f("jal_mem", F_MEMSEL, 4'b0000);
        expect_f("jal_alu1", F_ALU1, 4'b0001);
        expect_f("jal_imm", F_IMM, 4'b0010);
        expect_f("jal_pc", F_PC, 4'b0000);
        settle_check("jal");

        drive(OPC_BRANCH, 3'b110, 7'b0, 1'b0);
        expect_f("cmp_110", F_CMP, 4'b0100);
        expect_f("sel_110", F_SEL, 4'b0010);
        settle_check("f3_110");
        drive(OPC_BRANCH, 3'b101, 7'b0, 1'b0);
        expect_f("cmp_101", F_CMP, 4'b0011);
        expect_f("sel_101", F_SEL, 4'b0100);
        settle_check("f3_101");
        drive(OPC_BRANCH, 3'b000, 7'b0, 1'b0);
        expect_f("cmp_000", F_CMP, 4'b0000);
        expect_f("sel_000", F_SEL, 4'b0000);
        settle_check("f3_000");
        drive(OPC_LUI, 3'b100, 7'b0, 1'b0);
        expect_f("cmp_100", F_CMP, 4'b0010);
        expect_f("sel_100", F_SEL, 4'b0011);
        settle_check("f3_100");
        drive(OPC_LUI, 3'b001, 7'b0, 1'b0);
        expect_f("cmp_001", F_CMP, 4'b0001);
        expect_f("sel_001", F_SEL, 4'b0001);
        settle_check("f3_001");
        drive(OPC_LUI, 3'b011, 7'b0, 1'b0);
        expect_f("cmp_011", F_CMP, 4'b0000);
        expect_f("sel_011", F_SEL, 4'b0010);
        settle_check("f3_011");
        drive(OPC_LUI, 3'b111, 7'b0, 1'b0);
        expect_f("cmp_111", F_CMP, 4'b0101);
        expect_f("sel_111", F_SEL, 4'b0010);
        settle_check("f3_111");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/ctrl_unit.md
# ctrl_unit

Main decoder and control block (`ctrl`) of the RV32I single-issue core, sitting between the instruction register and the datapath multiplexers, ALU, comparator, register file and memory interface. It decodes the 5-bit major opcode (instruction bits [6:2]), func3 and func7 into mux selects, write enables and operation codes. Its only state is a one-bit `load_phase` register that splits LOAD into an address phase and a write-back phase, stalling the PC during the address phase.

## Interface
- No parameters.
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  synchronous reset, active-low: `rst=0` at a rising edge clears `load_phase` to 0.
- `opcode`  in  5  instruction bits [6:2].
  - OP=01100, OP_IMM=00100, LOAD=00000, STORE=01000, BRANCH=11000, JAL=11011, JALR=11001, LUI=01101, AUIPC=00101.
- `func3`  in  3  instruction bits [14:12].
- `func7`  in  7  instruction bits [31:25].
- `b`  in  1  comparator result; 1 = branch condition true.
- `imm_type`  out  3  immediate format: 000 none, 001 U, 010 J, 011 S, 100 I, 101 B.
- `alu1_sel`  out  1  ALU operand A: 0 = rs1, 1 = PC.
- `alu2_sel`  out  1  ALU operand B: 0 = rs2, 1 = immediate.
- `alu_op`  out  4  ALU operation: 0000 ADD, 0001 SUB, 0010 SLL, 0011 SLT, 0100 SLTU, 0101 XOR, 0110 SRL, 0111 SRA, 1000 OR, 1001 AND.
- `rd_sel`  out  2  write-back source: 00 immediate, 01 PC+4, 10 ALU result, 11 memory data.
- `reg_wr`  out  1  register-file write enable.
- `pc_sel`  out  2  next PC: 00 ALU result, 01 PC+4, 10 hold PC.
- `mem_sel`  out  2  memory address source: 00 PC (fetch), 01 ALU result (data); 1x unused.
- `mem_wr`  out  1  data memory write enable.
- `cmp_op`  out  3  comparator op: 000 EQ, 001 NE, 010 LT, 011 GE, 100 LTU, 101 GEU.
- `sel_type`  out  3  access size: 000 byte, 001 half, 010 word, 011 byte unsigned, 100 half unsigned.

## Operation
- `imm_type`: LUI/AUIPC→001, JAL→010, STORE→011, OP_IMM/LOAD/JALR→100, BRANCH→101, any other opcode→000.
- `alu1_sel` = 1 for JAL, BRANCH and AUIPC; 0 otherwise, including LOAD.
- `alu2_sel` = 0 only for OP; 1 for every other opcode, including undefined ones.
- `alu_op`:
  - OP: func3 000→ADD, or SUB when func7[5]=1; 001 SLL; 010 SLT; 011 SLTU; 100 XOR; 101→SRL, or SRA when func7[5]=1; 110 OR; 111 AND.
  - OP_IMM: same mapping, except func3 000 is always ADD.
  - All other opcodes: ADD.
- `rd_sel`: LUI→00, JAL/JALR→01, LOAD→11, everything else→10.
- `reg_wr`:
  - 1 for OP, OP_IMM, LUI, AUIPC, JAL and JALR.
  - LOAD: equals `load_phase`.
  - 0 for STORE, BRANCH and undefined opcodes.
- `pc_sel`:
  - JAL/JALR→00.
  - BRANCH→00 if `b=1`, else 01.
  - LOAD→10 when `load_phase=0`, 01 when `load_phase=1`.
  - Everything else→01.
- `mem_sel`: STORE→01; LOAD→01 when `load_phase=0`, 00 when `load_phase=1`; everything else→00.
- `mem_wr` = 1 only for STORE.
- `cmp_op` is decoded from func3 regardless of opcode:
  - 000→000, 001→001, 100→010, 101→011, 110→100, 111→101.
  - 010 and 011→000.
- `sel_type` is decoded from func3 regardless of opcode:
  - 000→000, 001→001, 010→010, 100→011, 101→100.
  - 011, 110 and 111→010.
- `load_phase` next state:
  - 0 if `rst=0`.
  - Otherwise 1 when `opcode=LOAD` and `load_phase=0`.
  - Otherwise 0.

## Timing
- All outputs are purely combinational from `opcode`, `func3`, `func7`, `b` and `load_phase`, with zero latency and no X outputs once `load_phase` is defined.
- `load_phase` is the only register. Its value after reset is 0, so after reset every output is the combinational decode with `load_phase=0`.
- LOAD takes exactly two cycles:
  - Cycle 1 (`load_phase=0`): `pc_sel=10`, `mem_sel=01`, `reg_wr=0`.
  - Cycle 2 (`load_phase=1`): `pc_sel=01`, `mem_sel=00`, `reg_wr=1`.
  - The next edge then returns `load_phase` to 0.
- Reset asserted mid-LOAD forces `load_phase=0` at the next edge; the LOAD restarts at phase 0.
- A non-LOAD opcode at any edge clears `load_phase`.

## Test plan
- Apply `rst=0` for one edge, then `opcode=LUI`, OP_IMM and STORE in turn → `imm_type` = 001, 100 and 011 respectively.
- `opcode=OP`, then 10101, then OP_IMM → `alu2_sel` = 0, 1, 1. With OP, func3=000, func7=0100000 → `alu_op=0001`. With OP_IMM and the same func3/func7 → `alu_op=0000`.
- `opcode=BRANCH`: `b=0` → `pc_sel=01`; `b=1` → `pc_sel=00`. `opcode=JALR` → `pc_sel=00`, `rd_sel=01`, `reg_wr=1`.
- LOAD held for two edges after reset:
  - Cycle 1 → `pc_sel=10`, `mem_sel=01`, `reg_wr=0`, `rd_sel=11`.
  - Cycle 2 → `pc_sel=01`, `mem_sel=00`, `reg_wr=1`.
  - Cycle 3 (still LOAD) → back to phase-0 values.
- STORE → `mem_sel=01`, `mem_wr=1`, `reg_wr=0`. Opcode 11011 (JAL) → `mem_sel=00`, `alu1_sel=1`.
- Sweep func3:
  - 110 → `cmp_op=100`, 101 → `cmp_op=011`, 000 → `cmp_op=000`.
  - 101 → `sel_type=100`, 100 → `sel_type=011`, 001 → `sel_type=001`.
